vector_dac_scheduler: RTL and testbench

Sequences beam samples (X, Y, intensity) from the vectrex core onto a shared serial DAC shifter driving MCP4922-class dual DACs: chip 0 holds X on channel A and Y on channel B; chip 1 holds intensity on channel A. Only changed channels are transferred. Intensity ordering depends on blank direction so the beam never streaks. Issues one LDAC latch pulse per sample after all transfers. Sits between the beam scaling logic and the SPI bit-shifter on the user port.

---
 rtl/vector_dac_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_vector_dac_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_dac_scheduler.sv
// Beam sample sequencer for the shared serial DAC shifter.
// Sends only changed channels, orders intensity by blank direction, then latches.
module vector_dac_scheduler #(
  parameter int         LAT_CYCLES    = 2,
  parameter int         SETTLE_CYCLES = 16,
  parameter logic [2:0] CTRL_BITS     = 3'b011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_x,
  input  logic [11:0] in_y,
  input  logic [11:0] in_i,
  input  logic        spi_ready,
  output logic        spi_start,
  output logic [15:0] spi_word,
  output logic        spi_sel,
  input  logic        spi_done,
  output logic        dac_lat_n,
  output logic        busy,
  output logic [15:0] upd_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_LATCH, S_SETTLE
  } state_t;

  localparam logic [1:0] IT_X = 2'd0;
  localparam logic [1:0] IT_Y = 2'd1;
  localparam logic [1:0] IT_I = 2'd2;

  state_t      state_q, state_d;
  logic        full_q;
  logic [11:0] hx_q, hy_q, hi_q;
  logic [11:0] wx_q, wy_q, wi_q;
  logic [11:0] cur_x, cur_y, cur_i;
  logic        primed_q;
  logic [2:0]  pend_q;
  logic        dim_q;
  logic [15:0] cnt_q;
  logic        start_q;
  logic [15:0] word_q;
  logic        sel_q;
  logic        lat_n_q;
  logic [15:0] upd_q;

  logic        accept;
  logic [2:0]  chg;
  logic [1:0]  head;
  logic [2:0]  pend_rest;
  logic [15:0] item_word;
  logic        item_sel;
  logic        lat_end;
  logic        set_end;

  assign accept    = in_valid & ~full_q;
  assign in_ready  = ~full_q;
  assign spi_start = start_q;
  assign spi_word  = word_q;
  assign spi_sel   = sel_q;
  assign dac_lat_n = lat_n_q;
  assign busy      = (state_q != S_IDLE);
  assign upd_count = upd_q;

  // Unprimed outputs hold unknown codes, so everything is refreshed.
  assign chg[0] = ~primed_q | (hx_q != cur_x);
  assign chg[1] = ~primed_q | (hy_q != cur_y);
  assign chg[2] = ~primed_q | (hi_q != cur_i);

  assign pend_rest = pend_q & ~(3'b001 << head);
  assign lat_end   = (cnt_q == 16'(LAT_CYCLES - 1));
  assign set_end   = (cnt_q == 16'(SETTLE_CYCLES - 1));

  // Dimming sends intensity first so the beam never streaks.
  always_comb begin
    head = IT_I;
    if (dim_q && pend_q[2]) head = IT_I;
    else if (pend_q[0])     head = IT_X;
    else if (pend_q[1])     head = IT_Y;
  end

  always_comb begin
    item_word = {1'b0, CTRL_BITS, wx_q};
    item_sel  = 1'b0;
    case (head)
      IT_Y: item_word = {1'b1, CTRL_BITS, wy_q};
      IT_I: begin
        item_word = {1'b0, CTRL_BITS, wi_q};
        item_sel  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (full_q) state_d = S_LOAD;
      S_LOAD:   state_d = (chg == 3'b000) ? S_IDLE : S_ISSUE;
      S_ISSUE:  if (spi_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (spi_done)
          state_d = (pend_rest == 3'b000) ? S_LATCH : S_ISSUE;
      end
      S_LATCH: begin
        if (lat_end)
          state_d = (SETTLE_CYCLES == 0) ? S_IDLE : S_SETTLE;
      end
      S_SETTLE: if (set_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      full_q   <= 1'b0;
      hx_q     <= '0;
      hy_q     <= '0;
      hi_q     <= '0;
      wx_q     <= '0;
      wy_q     <= '0;
      wi_q     <= '0;
      cur_x    <= 12'h800;
      cur_y    <= 12'h800;
      cur_i    <= '0;
      primed_q <= 1'b0;
      pend_q   <= '0;
      dim_q    <= 1'b0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      word_q   <= '0;
      sel_q    <= 1'b0;
      lat_n_q  <= 1'b1;
      upd_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= 1'b0;
      if (accept) begin
        full_q <= 1'b1;
        hx_q   <= in_x;
        hy_q   <= in_y;
        hi_q   <= in_i;
      end else if (state_q == S_LOAD) begin
        full_q <= 1'b0;
      end
      unique case (state_q)
        S_LOAD: begin
          wx_q   <= hx_q;
          wy_q   <= hy_q;
          wi_q   <= hi_q;
          pend_q <= chg;
          dim_q  <= (hi_q < cur_i);
        end
        S_ISSUE: begin
          if (spi_ready) begin
            start_q <= 1'b1;
            word_q  <= item_word;
            sel_q   <= item_sel;
          end
        end
        S_WAIT: begin
          if (spi_done) begin
            case (head)
              IT_X:    cur_x <= wx_q;
              IT_Y:    cur_y <= wy_q;
              default: cur_i <= wi_q;
            endcase
            pend_q <= pend_rest;
            if (pend_rest == 3'b000) begin
              lat_n_q <= 1'b0;
              cnt_q   <= '0;
            end
          end
        end
        S_LATCH: begin
          if (lat_end) begin
            lat_n_q  <= 1'b1;
            primed_q <= 1'b1;
            upd_q    <= upd_q + 16'd1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_SETTLE: cnt_q <= cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_dac_scheduler.sv
// Scoreboard bench for vector_dac_scheduler with a delayed-done shifter model.
module tb_vector_dac_scheduler;

  localparam int K = 3;

  logic        clock = 0;
  logic        reset = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [11:0] in_x = 0, in_y = 0, in_i = 0;
  logic        spi_ready;
  logic        spi_start;
  logic [15:0] spi_word;
  logic        spi_sel;
  logic        spi_done = 0;
  logic        dac_lat_n;
  logic        busy;
  logic [15:0] upd_count;

  logic rdy_en = 1;
  logic sh_busy = 0;
  assign spi_ready = rdy_en & ~sh_busy;

  vector_dac_scheduler dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_i(in_i),
    .spi_ready(spi_ready), .spi_start(spi_start),
    .spi_word(spi_word), .spi_sel(spi_sel),
    .spi_done(spi_done), .dac_lat_n(dac_lat_n),
    .busy(busy), .upd_count(upd_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int t_acc = 0;
  int n_lat = 0;
  int lowcnt = 0;
  int exp_upd = 0;
  logic [16:0] sb[$];
  int starts[$];
  int rises[$];
  logic [16:0] mon_e;
  logic [11:0] cx = 12'h800, cy = 12'h800, ci = 12'h000;
  bit primed = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shifter: done pulse K cycles after each start.
  initial begin
    forever begin
      @(negedge clock);
      if (spi_start) begin
        sh_busy = 1;
        repeat (K) @(negedge clock);
        spi_done = 1;
        @(negedge clock);
        spi_done = 0;
        sh_busy = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (spi_start) begin
      starts.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_start", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("spi_word", spi_word, {16'h0, mon_e[15:0]});
        check("spi_sel", spi_sel, {31'h0, mon_e[16]});
      end
    end
    if (!dac_lat_n) begin
      lowcnt++;
    end else if (lowcnt != 0) begin
      check("lat_width", lowcnt, 2);
      n_lat++;
      rises.push_back(cyc);
      lowcnt = 0;
    end
  end

  task automatic expect_sample(input logic [11:0] x, y, i);
    bit chx, chy, chi;
    chx = !primed || (x != cx);
    chy = !primed || (y != cy);
    chi = !primed || (i != ci);
    if (i < ci) begin
      if (chi) sb.push_back({1'b1, 4'b0011, i});
      if (chx) sb.push_back({1'b0, 4'b0011, x});
      if (chy) sb.push_back({1'b0, 4'b1011, y});
    end else begin
      if (chx) sb.push_back({1'b0, 4'b0011, x});
      if (chy) sb.push_back({1'b0, 4'b1011, y});
      if (chi) sb.push_back({1'b1, 4'b0011, i});
    end
    if (chx || chy || chi) begin
      exp_upd++;
      primed = 1;
    end
    cx = x;
    cy = y;
    ci = i;
  endtask

  task automatic send(input logic [11:0] x, y, i);
    int n = 0;
    in_x = x;
    in_y = y;
    in_i = i;
    in_valid = 1;
    while (!in_ready && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("accept_timeout", n < 3000, 1);
    @(posedge clock);
    #1;
    in_valid = 0;
    t_acc = cyc;
    expect_sample(x, y, i);
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clock);
    while ((busy || !in_ready) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", n < 3000, 1);
    check("sb_empty", sb.size(), 0);
    check("latch_count", n_lat, exp_upd);
    check("upd_count", upd_count, exp_upd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  logic [15:0] w0;
  int n;

  initial begin
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_word", spi_word, 0);
    check("rst_spi_sel", spi_sel, 0);
    check("rst_lat_n", dac_lat_n, 1);
    check("rst_busy", busy, 0);
    check("rst_upd", upd_count, 0);

    // full refresh, X Y I order
    starts.delete();
    send(12'h100, 12'h200, 12'hFFF);
    wait_idle();
    check("t1_starts", starts.size(), 3);
    check("t1_first_lat", starts[0] - t_acc, 3);
    check("t1_gap", starts[1] - starts[0], K + 2);

    // identical sample: nothing sent
    starts.delete();
    send(12'h100, 12'h200, 12'hFFF);
    wait_idle();
    check("t2_starts", starts.size(), 0);
    check("t2_in_ready", in_ready, 1);

    // blanking: I first, Y skipped
    starts.delete();
    send(12'h300, 12'h200, 12'h000);
    wait_idle();
    check("t3_starts", starts.size(), 2);

    // unblank: only I
    starts.delete();
    send(12'h300, 12'h200, 12'h800);
    wait_idle();
    check("t4_starts", starts.size(), 1);

    // shifter stalled in ISSUE, second sample queued
    starts.delete();
    rises.delete();
    rdy_en = 0;
    send(12'h400, 12'h500, 12'h600);
    repeat (3) @(negedge clock);
    w0 = spi_word;
    check("t5_busy", busy, 1);
    send(12'h700, 12'h710, 12'h720);
    check("t5_ready_fall", in_ready, 0);
    repeat (50) begin
      @(negedge clock);
      check("t5_start_hold", spi_start, 0);
      check("t5_word_hold", spi_word, w0);
    end
    rdy_en = 1;
    wait_idle();
    check("t5_starts", starts.size(), 6);
    check("t5_after_settle", starts[3] - rises[0], 19);

    // reset while waiting for done
    starts.delete();
    send(12'h123, 12'h456, 12'h789);
    n = 0;
    while (!spi_start && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("t6_start_timeout", n < 100, 1);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    check("t6_in_ready", in_ready, 1);
    check("t6_spi_start", spi_start, 0);
    check("t6_spi_word", spi_word, 0);
    check("t6_spi_sel", spi_sel, 0);
    check("t6_lat_n", dac_lat_n, 1);
    check("t6_busy", busy, 0);
    check("t6_upd", upd_count, 0);
    sb.delete();
    cx = 12'h800;
    cy = 12'h800;
    ci = 12'h000;
    primed = 0;
    exp_upd = 0;
    n_lat = 0;
    repeat (5) @(negedge clock);
    check("t6_stray_busy", busy, 0);
    starts.delete();
    send(12'h800, 12'h800, 12'h000);
    wait_idle();
    check("t6_starts", starts.size(), 3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
